// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler for the single-cycle ALU: picks one ready RS entry per cycle and holds its result on the CDB until granted.
// Optional macro ALU_ISSUE_PERF_EN adds saturating issue/stall performance counters.
module alu_issue_sched #(
    parameter int NUM_RS    = 4,
    parameter int PAYLOAD_W = 128,
    parameter int IDX_W     = $clog2(NUM_RS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [NUM_RS-1:0]           rs_ready,
    input  logic [NUM_RS*PAYLOAD_W-1:0] rs_payload,
    output logic [NUM_RS-1:0]           rs_grant,
    output logic [PAYLOAD_W-1:0]        alu_payload,
    output logic                        alu_valid,
    output logic [IDX_W-1:0]            alu_idx,
    output logic                        cdb_req,
    input  logic                        cdb_gnt
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]                 perf_issue_cnt,
    output logic [31:0]                 perf_stall_cnt
`endif
);

    logic [PAYLOAD_W-1:0] alu_payload_r;
    logic                 alu_valid_r;
    logic [IDX_W-1:0]     alu_idx_r;
    logic [IDX_W-1:0]     rr_ptr_r;

    logic                 can_issue_s;
    logic                 found_s;
    logic [IDX_W-1:0]     winner_s;
    logic [IDX_W-1:0]     scan_idx_s;
    logic                 issue_s;
    logic [NUM_RS-1:0]    grant_s;

    // Slot is free when nothing is held or the held result leaves this cycle; flush and reset block issue.
    always_comb begin
        can_issue_s = rst && !flush && (!alu_valid_r || cdb_gnt);
    end

    // Rotating priority scan starting at rr_ptr; index arithmetic wraps naturally since NUM_RS is a power of 2.
    always_comb begin
        found_s    = 1'b0;
        winner_s   = {IDX_W{1'b0}};
        scan_idx_s = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_RS; k++) begin
            scan_idx_s = rr_ptr_r + IDX_W'(k);
            if (!found_s && rs_ready[scan_idx_s]) begin
                found_s  = 1'b1;
                winner_s = scan_idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // One-hot dequeue strobe back to the reservation station.
    always_comb begin
        issue_s = can_issue_s && found_s;
        if (issue_s) begin
            grant_s = {{(NUM_RS-1){1'b0}}, 1'b1} << winner_s;
        end else begin
            grant_s = {NUM_RS{1'b0}};
        end
    end

    // Issue register and round-robin pointer; a new issue replaces a departing result in the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_payload_r <= {PAYLOAD_W{1'b0}};
            alu_valid_r   <= 1'b0;
            alu_idx_r     <= {IDX_W{1'b0}};
            rr_ptr_r      <= {IDX_W{1'b0}};
        end else if (issue_s) begin
            alu_payload_r <= rs_payload[winner_s*PAYLOAD_W +: PAYLOAD_W];
            alu_valid_r   <= 1'b1;
            alu_idx_r     <= winner_s;
            rr_ptr_r      <= winner_s + {{(IDX_W-1){1'b0}}, 1'b1};
        end else if (flush || (alu_valid_r && cdb_gnt)) begin
            alu_valid_r   <= 1'b0;
        end else begin
            alu_valid_r   <= alu_valid_r;
        end
    end

    assign rs_grant    = grant_s;
    assign alu_payload = alu_payload_r;
    assign alu_valid   = alu_valid_r;
    assign alu_idx     = alu_idx_r;
    assign cdb_req     = alu_valid_r;

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issue_cnt_r;
    logic [31:0] perf_stall_cnt_r;

    function automatic logic [31:0] sat_inc(input logic [31:0] val);
        if (val == 32'hFFFF_FFFF) begin
            sat_inc = val;
        end else begin
            sat_inc = val + 32'd1;
        end
    endfunction

    // Saturating counters of issued instructions and cycles the result waited for the CDB.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_issue_cnt_r <= 32'd0;
            perf_stall_cnt_r <= 32'd0;
        end else begin
            if (issue_s) begin
                perf_issue_cnt_r <= sat_inc(perf_issue_cnt_r);
            end
            if (alu_valid_r && !cdb_gnt) begin
                perf_stall_cnt_r <= sat_inc(perf_stall_cnt_r);
            end
        end
    end

    assign perf_issue_cnt = perf_issue_cnt_r;
    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed self-checking bench for alu_issue_sched (NUM_RS=4, PAYLOAD_W=128).
module tb_alu_issue_sched;

    localparam int NUM_RS    = 4;
    localparam int PAYLOAD_W = 128;
    localparam int IDX_W     = 2;

    logic                        clk;
    logic                        rst;
    logic                        flush;
    logic [NUM_RS-1:0]           rs_ready;
    logic [NUM_RS*PAYLOAD_W-1:0] rs_payload;
    logic [NUM_RS-1:0]           rs_grant;
    logic [PAYLOAD_W-1:0]        alu_payload;
    logic                        alu_valid;
    logic [IDX_W-1:0]            alu_idx;
    logic                        cdb_req;
    logic                        cdb_gnt;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0]                 perf_issue_cnt;
    logic [31:0]                 perf_stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    alu_issue_sched #(.NUM_RS(NUM_RS), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .rs_ready(rs_ready), .rs_payload(rs_payload), .rs_grant(rs_grant),
        .alu_payload(alu_payload), .alu_valid(alu_valid), .alu_idx(alu_idx),
        .cdb_req(cdb_req), .cdb_gnt(cdb_gnt)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PAYLOAD_W-1:0] pl(input int i);
        logic [31:0] w;
        w  = 32'hC0DE_0000 | 32'(i);
        pl = {w, ~w, w ^ 32'h5A5A_5A5A, w + 32'h1111_1111};
    endfunction

    function automatic logic [NUM_RS-1:0] oh(input int i);
        logic [NUM_RS-1:0] one;
        one = 4'b0001;
        oh  = one << i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; cdb_gnt = 1'b0; rs_ready = 4'b1111;
        tick(); tick();
        total++; if (rs_grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b exp=0000", rs_grant); end
        total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", alu_valid); end
        total++; if (alu_payload !== 128'd0) begin bad++; $display("FAIL reset_payload got=%h exp=0", alu_payload); end
        total++; if (alu_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", alu_idx); end
        rst = 1'b1;
        #1;
        total++; if (rs_grant !== 4'b0001) begin bad++; $display("FAIL release_grant got=%b exp=0001", rs_grant); end
        tick();
        total++; if (alu_valid !== 1'b1 || cdb_req !== 1'b1) begin bad++; $display("FAIL release_valid got=%b/%b exp=1/1", alu_valid, cdb_req); end
        total++; if (alu_idx !== 2'd0) begin bad++; $display("FAIL release_idx got=%0d exp=0", alu_idx); end
        total++; if (alu_payload !== pl(0)) begin bad++; $display("FAIL release_payload got=%h exp=%h", alu_payload, pl(0)); end
    endtask

    // rr_ptr is 1 here, so all-ready with continuous CDB grant walks 1,2,3,0,1.
    task automatic test_round_robin();
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        rs_ready = 4'b1111; cdb_gnt = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            total++; if (rs_grant !== oh(exp_seq[k])) begin bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, rs_grant, oh(exp_seq[k])); end
            tick();
            total++; if (alu_idx !== 2'(exp_seq[k]) || alu_valid !== 1'b1) begin bad++; $display("FAIL rr_issue[%0d] got=%0d/%b exp=%0d/1", k, alu_idx, alu_valid, exp_seq[k]); end
            total++; if (alu_payload !== pl(exp_seq[k])) begin bad++; $display("FAIL rr_payload[%0d] got=%h exp=%h", k, alu_payload, pl(exp_seq[k])); end
        end
    endtask

    task automatic test_wrap();
        rs_ready = 4'b0100; cdb_gnt = 1'b1;
        #1;
        total++; if (rs_grant !== 4'b0100) begin bad++; $display("FAIL wrap_first got=%b exp=0100", rs_grant); end
        tick();
        total++; if (rs_grant !== 4'b0100) begin bad++; $display("FAIL wrap_scan got=%b exp=0100", rs_grant); end
        tick();
        total++; if (alu_idx !== 2'd2) begin bad++; $display("FAIL wrap_idx got=%0d exp=2", alu_idx); end
        rs_ready = 4'b1001;
        #1;
        total++; if (rs_grant !== 4'b1000) begin bad++; $display("FAIL wrap_ptr3 got=%b exp=1000", rs_grant); end
    endtask

    task automatic test_stall();
        rs_ready = 4'b0011; cdb_gnt = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (rs_grant !== 4'b0000) begin bad++; $display("FAIL stall_grant[%0d] got=%b exp=0000", k, rs_grant); end
            total++; if (alu_payload !== pl(2) || alu_valid !== 1'b1) begin bad++; $display("FAIL stall_hold[%0d] got=%h/%b exp=%h/1", k, alu_payload, alu_valid, pl(2)); end
            tick();
        end
        cdb_gnt = 1'b1;
        #1;
        total++; if (rs_grant !== 4'b0001) begin bad++; $display("FAIL stall_release got=%b exp=0001", rs_grant); end
        tick();
        total++; if (alu_idx !== 2'd0 || alu_valid !== 1'b1) begin bad++; $display("FAIL stall_reissue got=%0d/%b exp=0/1", alu_idx, alu_valid); end
    endtask

    task automatic test_flush();
        rs_ready = 4'b0001; cdb_gnt = 1'b1; flush = 1'b1;
        #1;
        total++; if (rs_grant !== 4'b0000) begin bad++; $display("FAIL flush_grant got=%b exp=0000", rs_grant); end
        tick();
        flush = 1'b0;
        total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", alu_valid); end
        rs_ready = 4'b1111; cdb_gnt = 1'b0;
        #1;
        total++; if (rs_grant !== 4'b0010) begin bad++; $display("FAIL flush_ptr got=%b exp=0010", rs_grant); end
        tick();
        total++; if (alu_idx !== 2'd1 || alu_valid !== 1'b1) begin bad++; $display("FAIL flush_reissue got=%0d/%b exp=1/1", alu_idx, alu_valid); end
    endtask

    task automatic test_drain();
        rs_ready = 4'b0000; cdb_gnt = 1'b1;
        #1;
        total++; if (rs_grant !== 4'b0000) begin bad++; $display("FAIL drain_grant got=%b exp=0000", rs_grant); end
        tick();
        total++; if (alu_valid !== 1'b0 || cdb_req !== 1'b0) begin bad++; $display("FAIL drain_valid got=%b/%b exp=0/0", alu_valid, cdb_req); end
        tick();
        total++; if (alu_valid !== 1'b0) begin bad++; $display("FAIL idle_gnt_ignored got=%b exp=0", alu_valid); end
    endtask

    task automatic test_reset_mid_stall();
        rs_ready = 4'b0100; cdb_gnt = 1'b0;
        #1;
        total++; if (rs_grant !== 4'b0100) begin bad++; $display("FAIL mid_pre_grant got=%b exp=0100", rs_grant); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (alu_valid !== 1'b0 || alu_payload !== 128'd0 || rs_grant !== 4'b0000) begin bad++; $display("FAIL mid_reset got=%b/%h/%b exp=0/0/0000", alu_valid, alu_payload, rs_grant); end
        tick();
        rst = 1'b1; rs_ready = 4'b1001;
        #1;
        total++; if (rs_grant !== 4'b0001) begin bad++; $display("FAIL mid_ptr_reset got=%b exp=0001", rs_grant); end
    endtask

`ifdef ALU_ISSUE_PERF_EN
    task automatic test_perf();
        total++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", perf_issue_cnt, perf_stall_cnt); end
        tick();
        cdb_gnt = 1'b0;
        tick(); tick();
        rs_ready = 4'b1111; cdb_gnt = 1'b1;
        repeat (4) tick();
        total++; if (perf_issue_cnt !== 32'd5) begin bad++; $display("FAIL perf_issue got=%0d exp=5", perf_issue_cnt); end
        total++; if (perf_stall_cnt !== 32'd2) begin bad++; $display("FAIL perf_stall got=%0d exp=2", perf_stall_cnt); end
        force dut.perf_issue_cnt_r = 32'hFFFF_FFFF;
        #1;
        release dut.perf_issue_cnt_r;
        tick();
        total++; if (perf_issue_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL perf_sat got=%h exp=ffffffff", perf_issue_cnt); end
    endtask
`endif

    initial begin
        rst = 1'b0; flush = 1'b0; cdb_gnt = 1'b0; rs_ready = 4'b0000;
        for (int i = 0; i < NUM_RS; i++) rs_payload[i*PAYLOAD_W +: PAYLOAD_W] = pl(i);
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_flush();
        test_drain();
        test_reset_mid_stall();
`ifdef ALU_ISSUE_PERF_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
